// File: rtl/color_pkg.sv
// rtl/color_pkg.sv - shared constants for the colour-depth controller
//
// Purpose: default geometry, channel/layer indices and reset depth fill
//          values shared by color_chan_ctr and color_depth_ctrl.
// Ports:   none (package).
// Config:  COLOR_AUTOREPEAT_EN is consumed by color_chan_ctr, not here.

package color_pkg;

   localparam int CH_W_DEF = 3;
   localparam int N_CH_DEF = 3;

   localparam int CH_RED   = 0;
   localparam int CH_GREEN = 1;
   localparam int CH_BLUE  = 2;

   localparam logic LAYER_CHAR = 1'b0;
   localparam logic LAYER_BCK  = 1'b1;

   localparam logic DIR_DOWN = 1'b0;
   localparam logic DIR_UP   = 1'b1;

   // Reset depths are expressed as a fill bit so they scale with CH_W:
   // character layer comes up fully bright, background fully dark.
   localparam logic CHAR_RST_FILL = 1'b1;
   localparam logic BCK_RST_FILL  = 1'b0;

   // Reload value that makes a hold counter reach dly again after per cycles.
   function automatic int repeat_reload(input int dly, input int per);
      return dly - per + 1;
   endfunction

endpackage

// File: rtl/color_chan_ctr.sv
// rtl/color_chan_ctr.sv - one colour channel: edge detect, auto-repeat, two layer depth counters
//
// Purpose: holds the character and background depth of one channel and steps
//          the selected one on a request press edge (or auto-repeat tick),
//          with saturate or wrap limiting.
// Ports:
//   clk        in   clock, all state on rising edge
//   reset      in   synchronous active-low reset
//   req        in   step request level for this channel
//   layer_sel  in   0 = character, 1 = background (sampled on trigger)
//   dir        in   1 = increment, 0 = decrement (sampled on trigger)
//   char_depth out  character layer depth
//   bck_depth  out  background layer depth
//   stepped    out  one-cycle pulse, step applied
//   clipped    out  one-cycle pulse, step blocked at a limit
// Config: COLOR_AUTOREPEAT_EN builds the per-channel hold counter.

module color_chan_ctr
   import color_pkg::*;
#(
   parameter int CH_W       = CH_W_DEF,
   parameter int WRAP       = 0,
   parameter int REPEAT_DLY = 12_500_000,
   parameter int REPEAT_PER = 2_500_000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req,
   input  logic            layer_sel,
   input  logic            dir,
   output logic [CH_W-1:0] char_depth,
   output logic [CH_W-1:0] bck_depth,
   output logic            stepped,
   output logic            clipped
);

   localparam logic [CH_W-1:0] DEPTH_MAX = '1;

   logic            prev;
   logic            edge_hit;
   logic            tick;
   logic            trig;
   logic [CH_W-1:0] cur;
   logic [CH_W-1:0] nxt;
   logic            at_limit;
   logic            blocked;

   assign edge_hit = req & ~prev;

`ifdef COLOR_AUTOREPEAT_EN
   localparam int              HOLD_W      = $clog2(REPEAT_DLY + 1);
   localparam logic [HOLD_W-1:0] HOLD_FIRE   = HOLD_W'(REPEAT_DLY);
   localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(repeat_reload(REPEAT_DLY, REPEAT_PER));
   localparam logic [HOLD_W-1:0] HOLD_ONE    = HOLD_W'(1);

   // hold_cnt = number of held cycles since the press edge; zero means
   // "not armed". Only a real press edge arms it, so a request still held
   // across reset never auto-repeats.
   logic [HOLD_W-1:0] hold_cnt;

   assign tick = req && (hold_cnt == HOLD_FIRE);

   always_ff @(posedge clk) begin
      if (!reset) begin
         hold_cnt <= '0;
      end else if (!req) begin
         hold_cnt <= '0;
      end else if (edge_hit) begin
         hold_cnt <= HOLD_ONE;
      end else if (tick) begin
         hold_cnt <= HOLD_RELOAD;
      end else if (hold_cnt != '0) begin
         hold_cnt <= hold_cnt + 1'b1;
      end
   end
`else
   // No hold counter; the repeat timing parameters have no effect here.
   assign tick = (REPEAT_DLY < 0) && (REPEAT_PER < 0);
`endif

   assign trig = edge_hit | tick;

   always_comb begin
      cur      = (layer_sel == LAYER_BCK) ? bck_depth : char_depth;
      at_limit = (dir == DIR_UP) ? (cur == DEPTH_MAX) : (cur == '0);
      // Natural modulo-2^CH_W arithmetic gives the wrap behaviour for free.
      nxt      = (dir == DIR_UP) ? cur + 1'b1 : cur - 1'b1;
   end

   assign blocked = (WRAP == 0) && at_limit;

   always_ff @(posedge clk) begin
      if (!reset) begin
         char_depth <= {CH_W{CHAR_RST_FILL}};
         bck_depth  <= {CH_W{BCK_RST_FILL}};
         // Forced high so a request held through reset is not seen as a press.
         prev       <= 1'b1;
         stepped    <= 1'b0;
         clipped    <= 1'b0;
      end else begin
         prev    <= req;
         stepped <= trig & ~blocked;
         clipped <= trig & blocked;
         if (trig && !blocked) begin
            if (layer_sel == LAYER_BCK) begin
               bck_depth <= nxt;
            end else begin
               char_depth <= nxt;
            end
         end
      end
   end

endmodule

// File: rtl/color_depth_ctrl.sv
// rtl/color_depth_ctrl.sv - per-layer RGB colour-depth controller for the VGA character path
//
// Purpose: N_CH independent channel counters, each with a character and a
//          background depth, stepped by push-button requests.
// Ports:
//   clk        in   clock
//   reset      in   synchronous active-low reset
//   layer_sel  in   0 = character layer, 1 = background layer
//   dir        in   1 = increment, 0 = decrement
//   ch_req     in   [N_CH] per-channel step request levels
//   char_rgb   out  [N_CH*CH_W] character depths, channel i at [i*CH_W +: CH_W]
//   bck_rgb    out  [N_CH*CH_W] background depths, same packing
//   stepped    out  [N_CH] one-cycle pulse per applied step
//   clipped    out  [N_CH] one-cycle pulse per step blocked by saturation
// Config: define COLOR_AUTOREPEAT_EN to enable hold-to-auto-repeat.

module color_depth_ctrl
   import color_pkg::*;
#(
   parameter int CH_W       = CH_W_DEF,
   parameter int N_CH       = N_CH_DEF,
   parameter int WRAP       = 0,
   parameter int REPEAT_DLY = 12_500_000,
   parameter int REPEAT_PER = 2_500_000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 layer_sel,
   input  logic                 dir,
   input  logic [N_CH-1:0]      ch_req,
   output logic [N_CH*CH_W-1:0] char_rgb,
   output logic [N_CH*CH_W-1:0] bck_rgb,
   output logic [N_CH-1:0]      stepped,
   output logic [N_CH-1:0]      clipped
);

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      color_chan_ctr #(
         .CH_W       (CH_W),
         .WRAP       (WRAP),
         .REPEAT_DLY (REPEAT_DLY),
         .REPEAT_PER (REPEAT_PER)
      ) u_chan (
         .clk        (clk),
         .reset      (reset),
         .req        (ch_req[i]),
         .layer_sel  (layer_sel),
         .dir        (dir),
         .char_depth (char_rgb[i*CH_W +: CH_W]),
         .bck_depth  (bck_rgb[i*CH_W +: CH_W]),
         .stepped    (stepped[i]),
         .clipped    (clipped[i])
      );
   end

endmodule
